dwa_elem_sched: RTL
===================

// Module: dwa_elem_sched
// PURPOSE
//  Data-weighted-averaging scheduler for the 18-element unit DAC. Converts a per-sample element
//  count into the 18-bit selection vector SV by rotating a start pointer, so all elements are used
//  equally. SV feeds the 18-input transition detector. The detector's ST vector returns to this
//  block, which accumulates a switching-activity count.
//  Sits between the noise-shaper/quantiser output and the unit-element drivers.
// PARAMETERS
//  N_ELEM    18  number of unit elements (SV/ST width); code range 0..N_ELEM
//  WARM_CYC  4   cycles SV is held all-zero after enable, before codes are accepted
//  CNT_W     16  width of the transition accumulator tr_cnt
// PORTS
//  clk       in   1       system clock, all flops on rising edge
//  rstn      in   1       asynchronous reset, active-low
//  en        in   1       scheduler enable; level-sensitive
//  mode      in   1       0 = DWA rotation; 1 = fixed thermometer (ptr forced to 0)
//  code      in   5       number of elements to switch on this sample, 0..18
//  code_vld  in   1       code qualifier, one sample per asserted cycle
//  code_rdy  out  1       1 only in RUN state; code is accepted when code_vld & code_rdy
//  st        in   N_ELEM  transition vector returned from the detector
//  clr_cnt   in   1       synchronous clear of tr_cnt and ovf_err
//  sv        out  N_ELEM  registered element selection vector
//  sv_vld    out  1       1-cycle pulse; high the cycle after a code is accepted
//  ptr       out  5       current rotation pointer, 0..17
//  tr_cnt    out  CNT_W   saturating sum of popcount(st) over the RUN cycles
//  ovf_err   out  1       sticky flag: a code >18 was accepted
// BEHAVIOUR
//  Reset: sv=0, sv_vld=0, ptr=0, tr_cnt=0, ovf_err=0, code_rdy=0, state=IDLE.
//  States:
//   - IDLE: sv=0.
//     IDLE->WARM when en=1.
//   - WARM: sv=0. A counter runs WARM_CYC cycles.
//     WARM->RUN when the counter reaches WARM_CYC-1.
//   - RUN: code_rdy=1.
//  In every state, en=0 forces ->IDLE on the next edge.
//   - sv clears to 0 on that edge. ptr and tr_cnt keep their values.
//   - A code presented in that same cycle is accepted; the forced zero overrides its sv.
//   - Reset mid-operation: asynchronous return to the reset values above.
//  Accepted code c, c clipped to 18 if c>18:
//   - ovf_err sets when the raw c >18.
//   - Next edge: sv bit i = 1 for i in {(ptr+k) mod 18 : k=0..c-1}, i.e. wrap-around at bit 17->0.
//   - Next edge: ptr <= (ptr+c) >= 18 ? ptr+c-18 : ptr+c (6-bit internal sum).
//   - Latency: code -> sv is 1 cycle. sv_vld pulses in the same cycle sv updates.
//  Boundary cases:
//   - c=0: sv=0, ptr unchanged.
//   - c=18: sv all ones, ptr unchanged.
//   - No accepted code in a RUN cycle: sv holds, sv_vld=0.
//  mode=1: ptr is held at 0, so sv is the plain thermometer code (bits 0..c-1).
//  mode 1->0 switch: rotation restarts from ptr=0.
//  tr_cnt, updated only in RUN: tr_cnt <= sat(tr_cnt + popcount(st)).
//   - Saturates at 2^CNT_W-1, no wrap.
//   - clr_cnt has priority over accumulation and clears ovf_err in the same edge.
// STRUCTURE
//  dac_dig_pkg holds:
//   - N_ELEM, code width 5, ptr width 5
//   - state enum {IDLE, WARM, RUN}
//   - popcount18 function
//  One combinational sub-module, therm_rot_mask (inputs: ptr, c; output: N_ELEM mask).
//   - Built as a thermometer mask of c, rotated left by ptr over N_ELEM bits.
//  Everything else lives in dwa_elem_sched: FSM, warm counter, ptr adder, accumulator.
// TESTING
//  1. Reset, en=1: sv=0 for 4 cycles. code_rdy rises on the 5th edge after en.
//  2. mode=0, ptr=0, codes 5,5,5,5 -> sv 0x0001F, 0x003E0, 0x07C00, then 0x38003 (wrap, bits 15-17 and 0-1).
//     ptr sequence 5,10,15,2.
//  3. Codes 0 and 18 at ptr=7 -> sv 0x00000, then 0x3FFFF. ptr stays 7.
//  4. code=25 -> sv 0x3FFFF, ovf_err=1, ptr unchanged. clr_cnt=1 -> ovf_err=0, tr_cnt=0.
//  5. mode=1, codes 3 then 9 -> sv 0x00007, then 0x001FF. ptr stays 0.
//  6. Accumulator:
//     - st=0x3FFFF for 4 RUN cycles -> tr_cnt=72.
//     - With tr_cnt preset near max (CNT_W=8 build) it saturates at 255.
//     - en=0 mid-stream -> sv=0 next edge, tr_cnt holds.

Source files
------------

// File: rtl/dac_dig_pkg.sv
// Shared types and helpers for the unit-element DAC digital back end.
package dac_dig_pkg;

  localparam int N_ELEM = 18;
  localparam int CODE_W = 5;
  localparam int PTR_W  = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WARM = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  function automatic logic [4:0] popcount18(input logic [N_ELEM-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < N_ELEM; i++) n = n + {4'd0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/therm_rot_mask.sv
// Thermometer mask of c ones, rotated left by ptr across the element ring.
module therm_rot_mask
  import dac_dig_pkg::*;
(
  input  logic [PTR_W-1:0]  ptr_i,
  input  logic [CODE_W-1:0] c_i,
  output logic [N_ELEM-1:0] mask_o
);

  logic [N_ELEM-1:0]   therm;
  logic [2*N_ELEM-1:0] dbl;

  always_comb begin
    therm = '0;
    for (int i = 0; i < N_ELEM; i++) therm[i] = (CODE_W'(i) < c_i);
  end

  // Shifting two concatenated copies left and keeping the upper half yields the rotation.
  assign dbl    = {therm, therm} << ptr_i;
  assign mask_o = dbl[2*N_ELEM-1:N_ELEM];

endmodule

// File: rtl/dwa_elem_sched.sv
// DWA element scheduler: rotates a start pointer over the unit elements and
// accumulates the switching activity returned by the transition detector.
module dwa_elem_sched
  import dac_dig_pkg::*;
#(
  parameter int WARM_CYC = 4,
  parameter int CNT_W    = 16
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              en_i,
  input  logic              mode_i,
  input  logic [CODE_W-1:0] code_i,
  input  logic              code_vld_i,
  output logic              code_rdy_o,
  input  logic [N_ELEM-1:0] st_i,
  input  logic              clr_cnt_i,
  output logic [N_ELEM-1:0] sv_o,
  output logic              sv_vld_o,
  output logic [PTR_W-1:0]  ptr_o,
  output logic [CNT_W-1:0]  tr_cnt_o,
  output logic              ovf_err_o
);

  // state   | meaning
  // IDLE    | disabled, sv held at zero
  // WARM    | sv zero while the warm-up down-counter expires
  // RUN     | codes accepted, sv updated, activity accumulated

  localparam int WCW = (WARM_CYC > 1) ? $clog2(WARM_CYC) : 1;

  state_e            state_q, state_d;
  logic [WCW-1:0]    warm_q, warm_d;
  logic [N_ELEM-1:0] sv_q, sv_d;
  logic              sv_vld_q;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  tr_cnt_q, tr_cnt_d;
  logic              ovf_q, ovf_d;

  logic              accept;
  logic              code_big;
  logic [CODE_W-1:0] c_clip;
  logic [PTR_W-1:0]  ptr_eff;
  logic [5:0]        ptr_sum;
  logic [PTR_W-1:0]  ptr_nxt;
  logic [N_ELEM-1:0] mask;
  logic [CNT_W:0]    acc_sum;

  assign code_rdy_o = (state_q == ST_RUN);
  assign accept     = code_vld_i & code_rdy_o;
  assign code_big   = (code_i > CODE_W'(N_ELEM));
  assign c_clip     = code_big ? CODE_W'(N_ELEM) : code_i;
  assign ptr_eff    = mode_i ? '0 : ptr_q;
  assign ptr_sum    = {1'b0, ptr_eff} + {1'b0, c_clip};
  assign ptr_nxt    = (ptr_sum >= 6'(N_ELEM)) ? PTR_W'(ptr_sum - 6'(N_ELEM)) : ptr_sum[PTR_W-1:0];
  assign acc_sum    = {1'b0, tr_cnt_q} + {{(CNT_W-4){1'b0}}, popcount18(st_i)};

  therm_rot_mask u_mask (
    .ptr_i  (ptr_eff),
    .c_i    (c_clip),
    .mask_o (mask)
  );

  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    case (state_q)
      ST_IDLE: if (en_i) begin
        state_d = ST_WARM;
        warm_d  = WCW'(WARM_CYC - 1);
      end
      ST_WARM: begin
        if (warm_q == '0) state_d = ST_RUN;
        else              warm_d  = warm_q - 1'b1;
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
    if (!en_i) state_d = ST_IDLE;
  end

  always_comb begin
    sv_d = sv_q;
    if (!en_i || state_q != ST_RUN) sv_d = '0;
    else if (accept)                sv_d = mask;

    ptr_d = ptr_q;
    if (mode_i)      ptr_d = '0;
    else if (accept) ptr_d = ptr_nxt;

    tr_cnt_d = tr_cnt_q;
    ovf_d    = ovf_q;
    if (clr_cnt_i) begin
      tr_cnt_d = '0;
      ovf_d    = 1'b0;
    end else begin
      if (state_q == ST_RUN) tr_cnt_d = acc_sum[CNT_W] ? '1 : acc_sum[CNT_W-1:0];
      if (accept && code_big) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= ST_IDLE;
      warm_q   <= '0;
      sv_q     <= '0;
      sv_vld_q <= 1'b0;
      ptr_q    <= '0;
      tr_cnt_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      warm_q   <= warm_d;
      sv_q     <= sv_d;
      sv_vld_q <= accept;
      ptr_q    <= ptr_d;
      tr_cnt_q <= tr_cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  assign sv_o      = sv_q;
  assign sv_vld_o  = sv_vld_q;
  assign ptr_o     = ptr_q;
  assign tr_cnt_o  = tr_cnt_q;
  assign ovf_err_o = ovf_q;

endmodule
